// File: rtl/codel_drop_scheduler.sv
// CoDel per-dequeue drop controller: a one-cycle decision, then a serial
// integer sqrt and restoring divide that produce the next drop time.
module codel_drop_scheduler #(
  parameter int TIME_W  = 32,
  parameter int COUNT_W = 16,
  parameter int MTU     = 1500
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i__req_valid,
  output logic               o__req_ready,
  input  logic [TIME_W-1:0]  i__now,
  input  logic [TIME_W-1:0]  i__sojourn,
  input  logic [31:0]        i__qbytes,
  input  logic [TIME_W-1:0]  i__interval,
  input  logic [TIME_W-1:0]  i__target,
  output logic               o__resp_valid,
  output logic               o__drop,
  output logic               o__dropping,
  output logic [COUNT_W-1:0] o__count
);
  localparam int HALF   = COUNT_W / 2;
  localparam int STEP_W = $clog2(TIME_W + 1);

  typedef enum logic [1:0] {IDLE, EVAL, SQRT, DIV} state_t;
  state_t r_state, w_nextState;

  logic [TIME_W-1:0]  r_now, r_sojourn, r_interval, r_target;
  logic [31:0]        r_qbytes;
  logic [TIME_W-1:0]  r_firstAbove, r_dropNext, r_base, r_quot;
  logic               r_dropping;
  logic [COUNT_W-1:0] r_count;
  logic [HALF-1:0]    r_root, r_sqBit, r_rem;
  logic [STEP_W-1:0]  r_step;

  logic               w_ok, w_drop, w_law, w_droppingNext, w_qBit;
  logic [TIME_W-1:0]  w_firstAboveNext, w_base, w_faDiff, w_dnDiff, w_quotNext;
  logic [COUNT_W-1:0] w_countNext, w_trialSq;
  logic [HALF-1:0]    w_trial, w_remNext;
  logic [HALF:0]      w_remShift, w_divisor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (i__req_valid) w_nextState = EVAL;
      EVAL: w_nextState = w_law ? SQRT : IDLE;
      SQRT: if (r_sqBit[0]) w_nextState = DIV;
      DIV:  if (r_step == STEP_W'(TIME_W - 1)) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Decision: time comparisons are signed differences so they survive wrap.
  always_comb begin
    w_firstAboveNext = r_firstAbove;
    w_ok             = 1'b0;
    w_drop           = 1'b0;
    w_law            = 1'b0;
    w_droppingNext   = r_dropping;
    w_countNext      = r_count;
    w_base           = r_dropNext;
    w_faDiff         = r_now - r_firstAbove;
    w_dnDiff         = r_now - r_dropNext;
    if (r_sojourn < r_target || r_qbytes <= 32'(MTU)) begin
      w_firstAboveNext = '0;
    end else if (r_firstAbove == '0) begin
      w_firstAboveNext = r_now + r_interval;
    end else begin
      w_ok = ~w_faDiff[TIME_W-1];
    end
    if (r_dropping) begin
      if (!w_ok) begin
        w_droppingNext = 1'b0;
      end else if (!w_dnDiff[TIME_W-1]) begin
        w_drop      = 1'b1;
        w_law       = 1'b1;
        w_countNext = (r_count == '1) ? r_count : r_count + COUNT_W'(1);
      end
    end else if (w_ok) begin
      w_drop         = 1'b1;
      w_law          = 1'b1;
      w_droppingNext = 1'b1;
      w_base         = r_now;
      // Re-entering soon after the last episode resumes near the old rate.
      if (r_count > COUNT_W'(2) && w_dnDiff < (r_interval << 4))
        w_countNext = r_count - COUNT_W'(2);
      else
        w_countNext = COUNT_W'(1);
    end
  end

  always_comb begin
    w_trial    = r_root | r_sqBit;
    w_trialSq  = COUNT_W'(w_trial) * COUNT_W'(w_trial);
    w_remShift = {r_rem, r_quot[TIME_W-1]};
    w_divisor  = {1'b0, r_root};
    w_qBit     = (w_remShift >= w_divisor);
    w_remNext  = w_qBit ? HALF'(w_remShift - w_divisor) : w_remShift[HALF-1:0];
    w_quotNext = {r_quot[TIME_W-2:0], w_qBit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_now <= '0; r_sojourn <= '0; r_interval <= '0; r_target <= '0;
      r_qbytes <= '0; r_firstAbove <= '0; r_dropNext <= '0; r_base <= '0;
      r_quot <= '0; r_dropping <= 1'b0; r_count <= '0; r_root <= '0;
      r_sqBit <= '0; r_rem <= '0; r_step <= '0;
    end else begin
      case (r_state)
        IDLE: if (i__req_valid) begin
          r_now      <= i__now;
          r_sojourn  <= i__sojourn;
          r_qbytes   <= i__qbytes;
          r_interval <= i__interval;
          r_target   <= i__target;
        end
        EVAL: begin
          r_firstAbove <= w_firstAboveNext;
          r_dropping   <= w_droppingNext;
          r_count      <= w_countNext;
          r_base       <= w_base;
          r_root       <= '0;
          r_sqBit      <= {1'b1, {(HALF-1){1'b0}}};
          r_quot       <= r_interval;
          r_rem        <= '0;
          r_step       <= '0;
        end
        SQRT: begin
          if (w_trialSq <= r_count) r_root <= w_trial;
          r_sqBit <= r_sqBit >> 1;
        end
        DIV: begin
          r_rem  <= w_remNext;
          r_quot <= w_quotNext;
          r_step <= r_step + STEP_W'(1);
          if (r_step == STEP_W'(TIME_W - 1)) r_dropNext <= r_base + w_quotNext;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o__req_ready  = (r_state == IDLE);
    o__resp_valid = (r_state == EVAL);
    o__drop       = (r_state == EVAL) && w_drop;
    o__dropping   = r_dropping;
    o__count      = r_count;
  end
endmodule
